// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, small-sigma rotate/shift amounts,
// the schedule FSM state type and a rotate-right helper.
package sha256_pkg;

    localparam int SHA256_WORD_W      = 32;
    localparam int SHA256_BLOCK_WORDS = 16;
    localparam int SHA256_ROUNDS      = 64;

    localparam int unsigned SIG0_ROT_A = 7;
    localparam int unsigned SIG0_ROT_B = 18;
    localparam int unsigned SIG0_SHR   = 3;

    localparam int unsigned SIG1_ROT_A = 17;
    localparam int unsigned SIG1_ROT_B = 19;
    localparam int unsigned SIG1_SHR   = 10;

    typedef logic [SHA256_WORD_W-1:0] word_t;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sched_state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (SHA256_WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma0.sv
// SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3, purely combinational.
module sha256_sigma0
    import sha256_pkg::*;
(
    input  word_t x,
    output word_t y
);

    assign y = rotr(x, SIG0_ROT_A) ^ rotr(x, SIG0_ROT_B) ^ (x >> SIG0_SHR);

endmodule

// File: rtl/sha256_sigma1.sv
// SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10, purely combinational.
module sha256_sigma1
    import sha256_pkg::*;
(
    input  word_t x,
    output word_t y
);

    assign y = rotr(x, SIG1_ROT_A) ^ rotr(x, SIG1_ROT_B) ^ (x >> SIG1_SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator. Loads one 512-bit block as 16 words,
// then streams W[0..63] from a 16-word sliding window.
// Optional macro SHA256_SCHED_IDX_EN adds out_idx (current round t).
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | in_ready=1, message words written into window slot load_cnt
// EMIT  | out_valid=1, out_word=win[0]=W[t], window shifts per handshake
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH  = SHA256_WORD_W,
    parameter int BLOCK_WORDS = SHA256_BLOCK_WORDS,
    parameter int ROUNDS      = SHA256_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_word,
    output logic                  out_last
`ifdef SHA256_SCHED_IDX_EN
    ,
    output logic [5:0]            out_idx
`endif
);

    localparam logic [3:0] LAST_LOAD = 4'(BLOCK_WORDS - 1);
    localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);

    sched_state_t state, state_nxt;
    logic [3:0]   load_cnt;
    logic [5:0]   t;
    word_t        win [BLOCK_WORDS];
    word_t        s0, s1, w_new;
    logic         in_hs, out_hs;

    sha256_sigma0 u_sigma0 (.x(win[1]),  .y(s0));
    sha256_sigma1 u_sigma1 (.x(win[14]), .y(s1));

    // Words produced for t >= 48 land in the window but are never emitted.
    assign w_new  = s1 + win[9] + s0 + win[0];
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (load_cnt == LAST_LOAD)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (t == LAST_T);
                if (out_ready && (t == LAST_T)) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Window load/shift and the load and round counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                win[k] <= '0;
            end
            load_cnt <= '0;
            t        <= '0;
        end else if (in_hs) begin
            win[load_cnt] <= in_word;
            load_cnt      <= load_cnt + 4'd1;
            t             <= '0;
        end else if (out_hs) begin
            for (int k = 0; k < BLOCK_WORDS - 1; k++) begin
                win[k] <= win[k+1];
            end
            win[BLOCK_WORDS-1] <= w_new;
            t                  <= t + 6'd1;
        end
    end

    assign out_word = out_valid ? win[0] : '0;

`ifdef SHA256_SCHED_IDX_EN
    assign out_idx = out_valid ? t : '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a direct W[t] expansion model.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_last;
`ifdef SHA256_SCHED_IDX_EN
    logic [5:0]  out_idx;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last)
`ifdef SHA256_SCHED_IDX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic build_expected();
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_expected();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        build_expected();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_expected();
    endtask

    // Runs on the posedge+1 phase; leaves on the posedge+1 phase.
    task automatic load_block(input int gap);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    total++;
                    if (in_ready !== 1'b1) begin
                        $display("FAIL gap_in_ready word=%0d got=%b want=1", i, in_ready); bad++;
                    end
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_word  = blk[i];
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                $display("FAIL load_in_ready word=%0d got=%b want=1", i, in_ready); bad++;
            end
            if (i == 15) begin
                total++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL early_out_valid got=%b want=0", out_valid); bad++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_word  = $urandom;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL first_out_latency out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); bad++;
        end
    endtask

    // Collects n_words handshakes with out_ready high ready_pct percent of cycles.
    task automatic collect_block(input int ready_pct, input int n_words, input bit junk_in);
        int          got_n = 0;
        int          cycles = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_word = '0;
        logic        prev_last = 1'b0;
        while (got_n < n_words && cycles < 4000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            if (junk_in) begin
                in_valid = $urandom_range(1);
                in_word  = $urandom;
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1) begin
                $display("FAIL out_valid_held t=%0d got=%b want=1", got_n, out_valid); bad++;
                break;
            end
            if (prev_stall) begin
                total++;
                if (out_word !== prev_word || out_last !== prev_last) begin
                    $display("FAIL stall_stable t=%0d word=%h/%h last=%b/%b", got_n, out_word, prev_word, out_last, prev_last); bad++;
                end
            end
`ifdef SHA256_SCHED_IDX_EN
            total++;
            if (out_idx !== 6'(got_n)) begin
                $display("FAIL out_idx got=%0d want=%0d", out_idx, got_n); bad++;
            end
`endif
            if (out_ready) begin
                total++;
                if (out_word !== exp_w[got_n]) begin
                    $display("FAIL out_word t=%0d got=%h want=%h", got_n, out_word, exp_w[got_n]); bad++;
                end
                total++;
                if (out_last !== (got_n == 63)) begin
                    $display("FAIL out_last t=%0d got=%b want=%b", got_n, out_last, (got_n == 63)); bad++;
                end
                got[got_n] = out_word;
                got_n++;
            end
            prev_stall = !out_ready;
            prev_word  = out_word;
            prev_last  = out_last;
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (got_n != n_words) begin
            $display("FAIL collect_count got=%0d want=%0d", got_n, n_words); bad++;
        end
        if (n_words == 64) begin
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL return_to_load in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_word !== 32'h0) begin
            $display("FAIL reset_values in_ready=%b out_valid=%b out_last=%b out_word=%h", in_ready, out_valid, out_last, out_word); bad++;
        end
`ifdef SHA256_SCHED_IDX_EN
        total++;
        if (out_idx !== 6'd0) begin
            $display("FAIL reset_idx got=%0d want=0", out_idx); bad++;
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        set_abc();
        load_block(0);
        collect_block(100, 64, 1'b0);
        total++;
        if (got[16] !== 32'h61626380) begin
            $display("FAIL abc_w16 got=%h want=61626380", got[16]); bad++;
        end
        total++;
        if (got[17] !== 32'h000F0000) begin
            $display("FAIL abc_w17 got=%h want=000f0000", got[17]); bad++;
        end
    endtask

    task automatic test_backpressure();
        set_abc();
        load_block(0);
        collect_block(50, 64, 1'b1);
    endtask

    task automatic test_gapped();
        set_abc();
        load_block(3);
        collect_block(100, 64, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_abc();
        load_block(0);
        collect_block(100, 64, 1'b0);
        set_zero();
        load_block(0);
        collect_block(100, 64, 1'b0);
    endtask

    task automatic test_random_blocks();
        for (int n = 0; n < 3; n++) begin
            set_random();
            load_block($urandom_range(2));
            collect_block(70, 64, 1'b1);
        end
    endtask

    task automatic test_reset_mid_emit();
        set_abc();
        load_block(0);
        collect_block(100, 20, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_word !== 32'h0) begin
            $display("FAIL mid_reset out_valid=%b in_ready=%b out_last=%b out_word=%h", out_valid, in_ready, out_last, out_word); bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        set_abc();
        load_block(0);
        collect_block(100, 64, 1'b0);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_gapped();
        test_back_to_back();
        test_random_blocks();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule generator: the producer side of the W-word stream that the sigma0/sigma1 functions operate on.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input.
- Emits W[0..63] one word per handshake over a valid/ready output, for the compression round engine.
- Uses a 16-word sliding window and instantiates the combinational sigma0/sigma1 functions for the expansion.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported (SHA-256).
- BLOCK_WORDS, 16, input words per block.
- ROUNDS, 64, schedule words emitted per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts an input word.
- in_word  input  DATA_WIDTH  message word M[i], in order i = 0..15.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  downstream accepts a word.
- out_word  output  DATA_WIDTH  schedule word W[t].
- out_last  output  1  high with out_valid when t = 63.

Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- State machine: LOAD and EMIT; reset state is LOAD.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_word=0, window cleared, counters cleared.
- LOAD:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready handshake writes in_word into window slot load_cnt and increments load_cnt (4 bits).
  - On the 16th handshake (load_cnt=15): go to EMIT, reset t=0, drop in_ready.
  - out_valid rises on the next cycle. Latency from the last input handshake to first out_valid is 1 cycle.
- EMIT:
  - out_valid=1, out_word=win[0] (=W[t]), in_ready=0.
  - On each out_valid&out_ready handshake, the window shifts down one slot (win[k]<=win[k+1]) and win[15] gets Wnew.
  - Wnew = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32, carries discarded.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t increments on each handshake (6 bits).
- Stall: while out_ready=0, out_word, out_last and window hold stable. out_valid must not drop once raised until the handshake.
- Last word: out_last=1 only when t=63.
  - On the t=63 handshake: return to LOAD, in_ready=1 next cycle.
  - Expansion words computed for t>=48 are don't-care and are never emitted.
- Throughput: one word per cycle with out_ready held high.
  - Block period = 16 load cycles + 64 emit cycles.
  - Input and output phases never overlap.
- in_valid during EMIT is ignored; no word is consumed.
- Reset mid-block, in either state: immediate return to reset values. A partially loaded or partially emitted block is discarded.

Optional Feature:
- Macro: SHA256_SCHED_IDX_EN.
- Defined: adds output port out_idx (6 bits), equal to t while out_valid=1.
  - Reset value 0; held stable during stall.
- Undefined: port and its logic are absent. t remains internal for out_last.

Decomposition:
- Shared package sha256_pkg:
  - SHA256_WORD_W=32, SHA256_BLOCK_WORDS=16, SHA256_ROUNDS=64.
  - Rotation/shift constants 7/18/3 and 17/19/10.
  - Typedefs word_t (32-bit) and sched_state_t {LOAD, EMIT}.
- Sub-modules: reuse the existing sigma0 instance, plus one new sub-module sigma1 (same style: two rotates and a shift, XORed).

Test Plan:
- Block "abc": input 0x61626380, 0x00000000 x14, 0x00000018, with out_ready=1.
  - Required: W0..W15 echo the input.
  - W16=0x61626380, W17=0x000F0000.
  - out_last is high only on the 64th word.
- Backpressure: same block with out_ready toggled randomly, 50%.
  - Required: identical 64-word sequence.
  - out_word stable during stalls; no word lost or duplicated.
- Gapped input: in_valid low for 3 cycles between words.
  - Required: in_ready stays 1, output identical to the "abc" case.
  - out_valid first rises exactly 1 cycle after the 16th handshake.
- Back-to-back blocks: "abc" block, then an all-zero block.
  - Required: in_ready returns the cycle after the t=63 handshake.
  - Second block emits all-zero W[0..63].
- Reset mid-EMIT: assert rst at t=20.
  - Required: out_valid=0 and in_ready=1 immediately.
  - A fresh "abc" load after reset produces the correct sequence from W0.
- SHA256_SCHED_IDX_EN defined: out_idx counts 0..63 in lockstep with handshakes and holds during stalls.
